wb_master_arbiter: RTL and testbench

//  Two-master Wishbone arbiter that shares the single master port of the

---
 rtl/wb_master_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_wb_master_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_master_arbiter.sv
// wb_master_arbiter
//
// Shares one Wishbone master port (towards the peripheral address mux)
// between two requesters, typically the SPI host bridge (m0) and the soft
// CPU (m1). Arbitration is round-robin and takes one cycle. A grant is kept
// for as long as the owner holds CYC, so locked bursts are never split.
// A per-transfer watchdog answers with ERR when a strobe stays unanswered
// for TIMEOUT cycles, which covers unmapped addresses and hung slaves.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   m0_* / m1_*         Wishbone slave-side ports, one per requesting master
//                       (adr/dat/we/sel/stb/cyc in, dat/ack/err out)
//   s_*                 Wishbone master-side port towards the address mux
//                       (adr/dat/we/sel/stb/cyc out, dat/ack/err in)
//
// Parameters
//   DATA_WIDTH, ADDR_WIDTH, SELECT_WIDTH  bus widths
//   TIMEOUT             unanswered strobe cycles before a forced ERR, 0 = off

module wb_master_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT      = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_dat_i,
  output logic [DATA_WIDTH-1:0]   m0_dat_o,
  input  logic                    m0_we_i,
  input  logic [SELECT_WIDTH-1:0] m0_sel_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_cyc_i,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,

  input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_dat_i,
  output logic [DATA_WIDTH-1:0]   m1_dat_o,
  input  logic                    m1_we_i,
  input  logic [SELECT_WIDTH-1:0] m1_sel_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_cyc_i,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,

  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  output logic                    s_we_o,
  output logic [SELECT_WIDTH-1:0] s_sel_o,
  output logic                    s_stb_o,
  output logic                    s_cyc_o,
  input  logic                    s_ack_i,
  input  logic                    s_err_i
);

  // Counter must hold TIMEOUT-1; keep at least one bit when the watchdog is off.
  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;
  localparam logic [WD_W-1:0] WD_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            last_gnt_q, last_gnt_d;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            wd_err_q, wd_err_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      wd_cnt_q   <= '0;
      wd_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      wd_cnt_q   <= wd_cnt_d;
      wd_err_q   <= wd_err_d;
    end
  end

  // Arbitration. On a tie in IDLE the master that did not own the bus last
  // wins. On release, a waiting master is handed the bus directly without
  // passing through IDLE.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = last_gnt_q ? GNT0 : GNT1;
        end else if (m0_cyc_i) begin
          state_d = GNT0;
        end else if (m1_cyc_i) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          last_gnt_d = 1'b0;
          state_d    = m1_cyc_i ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          last_gnt_d = 1'b1;
          state_d    = m0_cyc_i ? GNT0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus steering. Responses are qualified by the owner's CYC so an ack that
  // arrives after the owner abandoned its cycle is dropped. The watchdog
  // error cycle pulls CYC/STB low towards the slave.
  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_stb_o  = 1'b0;
    s_cyc_o  = 1'b0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    case (state_q)
      GNT0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_cyc_o  = m0_cyc_i & ~wd_err_q;
        s_stb_o  = m0_cyc_i & m0_stb_i & ~wd_err_q;
        m0_ack_o = m0_cyc_i & s_ack_i;
        m0_err_o = m0_cyc_i & (s_err_i | wd_err_q);
      end
      GNT1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_cyc_o  = m1_cyc_i & ~wd_err_q;
        s_stb_o  = m1_cyc_i & m1_stb_i & ~wd_err_q;
        m1_ack_o = m1_cyc_i & s_ack_i;
        m1_err_o = m1_cyc_i & (s_err_i | wd_err_q);
      end
      default: ;
    endcase
  end

  // Read data is broadcast; each master only looks at it with its own ack.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  // Watchdog. wd_cnt_q counts strobe cycles already spent waiting. A slave
  // response in the final cycle takes priority over the forced error. The
  // error pulse itself drops the strobe, which restarts the count.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    wd_err_d = 1'b0;
    if (!s_stb_o || s_ack_i || s_err_i) begin
      wd_cnt_d = '0;
    end else if ((TIMEOUT != 0) && (wd_cnt_q == WD_LAST)) begin
      wd_err_d = 1'b1;
      wd_cnt_d = '0;
    end else if (wd_cnt_q != WD_MAX) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// tb_wb_master_arbiter
//
// Drives the two-master arbiter with directed scenarios followed by a long
// randomized run. A per-cycle reference model (owner / round-robin pointer /
// count of unanswered strobe cycles) predicts every output of the arbiter.

module tb_wb_master_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = 4;
  localparam int TO = 16;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] m0_adr_i, m1_adr_i, s_adr_o;
  logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
  logic          m0_we_i, m1_we_i, s_we_o;
  logic [SW-1:0] m0_sel_i, m1_sel_i, s_sel_o;
  logic          m0_stb_i, m1_stb_i, m0_cyc_i, m1_cyc_i;
  logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic          s_stb_o, s_cyc_o, s_ack_i, s_err_i;

  int checks = 0;
  int errors = 0;

  // Reference model state: current owner (-1 = bus free), last owner,
  // consecutive unanswered strobe cycles, and the pending watchdog error.
  int mdl_owner;
  int mdl_last;
  int mdl_stall;
  bit mdl_fire;

  wb_master_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
    .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i), .m0_stb_i(m0_stb_i),
    .m0_cyc_i(m0_cyc_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
    .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i), .m1_stb_i(m1_stb_i),
    .m1_cyc_i(m1_cyc_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
    .s_we_o(s_we_o), .s_sel_o(s_sel_o), .s_stb_o(s_stb_o),
    .s_cyc_o(s_cyc_o), .s_ack_i(s_ack_i), .s_err_i(s_err_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    mdl_owner = -1;
    mdl_last  = 1;
    mdl_stall = 0;
    mdl_fire  = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic modelStep(input bit stb_seen);
    bit cyc [2];
    bit resp;
    bit fire_next;
    cyc[0] = m0_cyc_i;
    cyc[1] = m1_cyc_i;
    if (!rst_n) begin
      modelReset();
      return;
    end
    resp      = s_ack_i || s_err_i;
    fire_next = 1'b0;
    if (stb_seen && !resp) begin
      if (mdl_stall + 1 == TO) begin
        fire_next = 1'b1;
        mdl_stall = 0;
      end else begin
        mdl_stall++;
      end
    end else begin
      mdl_stall = 0;
    end
    mdl_fire = fire_next;
    if (mdl_owner < 0) begin
      if (cyc[0] && cyc[1]) mdl_owner = 1 - mdl_last;
      else if (cyc[0])      mdl_owner = 0;
      else if (cyc[1])      mdl_owner = 1;
    end else if (!cyc[mdl_owner]) begin
      mdl_last  = mdl_owner;
      mdl_owner = cyc[1 - mdl_owner] ? 1 - mdl_owner : -1;
    end
  endtask

  // One full clock cycle: compare every output against the model at the
  // falling edge, then step the model at the rising edge.
  task automatic applyStimulus();
    logic [AW-1:0] adr [2];
    logic [DW-1:0] dat [2];
    logic [SW-1:0] sel [2];
    bit            cyc [2];
    bit            stb [2];
    bit            we  [2];
    bit            ack [2];
    bit            err [2];
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    logic [SW-1:0] e_sel;
    bit            e_we, e_cyc, e_stb;
    int            o;
    @(negedge clk);
    adr[0] = m0_adr_i; adr[1] = m1_adr_i;
    dat[0] = m0_dat_i; dat[1] = m1_dat_i;
    sel[0] = m0_sel_i; sel[1] = m1_sel_i;
    cyc[0] = m0_cyc_i; cyc[1] = m1_cyc_i;
    stb[0] = m0_stb_i; stb[1] = m1_stb_i;
    we[0]  = m0_we_i;  we[1]  = m1_we_i;
    ack = '{1'b0, 1'b0};
    err = '{1'b0, 1'b0};
    e_adr = '0; e_dat = '0; e_sel = '0;
    e_we = 1'b0; e_cyc = 1'b0; e_stb = 1'b0;
    o = mdl_owner;
    if (o >= 0) begin
      e_adr  = adr[o];
      e_dat  = dat[o];
      e_sel  = sel[o];
      e_we   = we[o];
      e_cyc  = cyc[o] && !mdl_fire;
      e_stb  = cyc[o] && stb[o] && !mdl_fire;
      ack[o] = cyc[o] && s_ack_i;
      err[o] = cyc[o] && (s_err_i || mdl_fire);
    end
    checkOutput("s_cyc", s_cyc_o, e_cyc);
    checkOutput("s_stb", s_stb_o, e_stb);
    checkOutput("s_adr", s_adr_o, e_adr);
    checkOutput("s_dat", s_dat_o, e_dat);
    checkOutput("s_we", s_we_o, e_we);
    checkOutput("s_sel", s_sel_o, e_sel);
    checkOutput("m0_ack", m0_ack_o, ack[0]);
    checkOutput("m0_err", m0_err_o, err[0]);
    checkOutput("m1_ack", m1_ack_o, ack[1]);
    checkOutput("m1_err", m1_err_o, err[1]);
    checkOutput("m0_dat", m0_dat_o, s_dat_i);
    checkOutput("m1_dat", m1_dat_o, s_dat_i);
    @(posedge clk);
    modelStep(e_stb);
    #1;
  endtask

  task automatic idleInputs();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0;
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
    m0_adr_i = '0; m1_adr_i = '0; m0_dat_i = '0; m1_dat_i = '0;
    m0_sel_i = '1; m1_sel_i = '1;
    s_ack_i = 1'b0; s_err_i = 1'b0; s_dat_i = '0;
  endtask

  task automatic doReset();
    idleInputs();
    rst_n = 1'b0;
    applyStimulus();
    rst_n = 1'b1;
    #1;
    checkOutput("rst_cyc", s_cyc_o, 1'b0);
    checkOutput("rst_stb", s_stb_o, 1'b0);
    checkOutput("rst_m0_ack", m0_ack_o, 1'b0);
    checkOutput("rst_m1_err", m1_err_o, 1'b0);
  endtask

  initial begin
    int rise, err_at, ack_cnt, rec_n, silent;
    bit done;
    int rec [8];

    idleInputs();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    modelReset();

    // Scenario 1: m0 single read, slave answers two cycles after strobe.
    doReset();
    m0_adr_i = 32'h10; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    #1;
    checkOutput("t1_latency", s_cyc_o, 1'b0);
    applyStimulus();
    #1;
    checkOutput("t1_cyc", s_cyc_o, 1'b1);
    checkOutput("t1_adr", s_adr_o, 32'h10);
    applyStimulus();
    applyStimulus();
    s_ack_i = 1'b1; s_dat_i = 32'hDEADBEEF;
    #1;
    checkOutput("t1_ack", m0_ack_o, 1'b1);
    checkOutput("t1_rdata", m0_dat_o, 32'hDEADBEEF);
    checkOutput("t1_m1_ack", m1_ack_o, 1'b0);
    applyStimulus();
    idleInputs();
    applyStimulus();

    // Scenario 2: simultaneous request after reset, then direct hand-over.
    doReset();
    m0_adr_i = 32'h100; m1_adr_i = 32'h200;
    m0_cyc_i = 1'b1; m1_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_stb_i = 1'b1;
    applyStimulus();
    #1;
    checkOutput("t2_first", s_adr_o, 32'h100);
    applyStimulus();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    applyStimulus();
    #1;
    checkOutput("t2_handover_cyc", s_cyc_o, 1'b1);
    checkOutput("t2_handover_adr", s_adr_o, 32'h200);
    idleInputs();
    applyStimulus();

    // Scenario 3: both keep requesting, one transfer per cycle each.
    doReset();
    m0_adr_i = 32'h100; m1_adr_i = 32'h200;
    m0_stb_i = 1'b1; m1_stb_i = 1'b1; s_ack_i = 1'b1;
    rec_n = 0;
    for (int k = 0; k < 24 && rec_n < 8; k++) begin
      #1;
      if (s_cyc_o) begin
        rec[rec_n] = (s_adr_o == 32'h200) ? 1 : 0;
        rec_n++;
      end
      applyStimulus();
      if (rec_n > 0 && m0_cyc_i && m1_cyc_i && s_cyc_o) begin
        if (rec[rec_n-1] == 0) m0_cyc_i = 1'b0;
        else                   m1_cyc_i = 1'b0;
      end else begin
        m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
      end
    end
    checkOutput("t3_count", rec_n, 8);
    for (int i = 0; i < rec_n; i++) checkOutput("t3_order", rec[i], i % 2);
    idleInputs();
    applyStimulus();

    // Scenario 4: m1 write to an unmapped address, slave never answers.
    doReset();
    m1_adr_i = 32'hFF0; m1_we_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    rise = -1; err_at = -1;
    for (int k = 0; k < 40 && err_at < 0; k++) begin
      #1;
      if (s_stb_o && rise < 0) rise = k;
      if (m1_err_o) begin
        err_at = k;
        checkOutput("t4_stb_low", s_stb_o, 1'b0);
      end
      applyStimulus();
    end
    checkOutput("t4_err_delay", err_at - rise, TO);
    #1;
    checkOutput("t4_single_pulse", m1_err_o, 1'b0);
    applyStimulus();
    idleInputs();
    applyStimulus();

    // Scenario 5: ack lands on the last cycle before the watchdog fires.
    doReset();
    m0_adr_i = 32'h20; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    rise = -1; done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      s_ack_i = (rise >= 0 && k == rise + TO - 1);
      #1;
      if (s_stb_o && rise < 0) rise = k;
      if (s_ack_i) begin
        done = 1'b1;
        checkOutput("t5_ack", m0_ack_o, 1'b1);
        checkOutput("t5_no_err", m0_err_o, 1'b0);
      end
      applyStimulus();
    end
    checkOutput("t5_reached", done, 1'b1);
    s_ack_i = 1'b0;
    #1;
    checkOutput("t5_no_late_err", m0_err_o, 1'b0);
    applyStimulus();
    idleInputs();
    applyStimulus();

    // Scenario 6: reset lands in the middle of an m0 burst.
    doReset();
    m0_adr_i = 32'h0F00; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    m1_adr_i = 32'h2000; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    s_ack_i = 1'b1; ack_cnt = 0;
    for (int k = 0; k < 10 && ack_cnt < 2; k++) begin
      #1;
      if (m0_ack_o) ack_cnt++;
      applyStimulus();
      if (m0_ack_o) m0_adr_i = m0_adr_i + 32'h4;
    end
    checkOutput("t6_two_acks", ack_cnt, 2);
    rst_n = 1'b0;
    applyStimulus();
    #1;
    checkOutput("t6_rst_cyc", s_cyc_o, 1'b0);
    checkOutput("t6_rst_stb", s_stb_o, 1'b0);
    checkOutput("t6_rst_ack", m0_ack_o, 1'b0);
    rst_n = 1'b1; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    applyStimulus();
    #1;
    checkOutput("t6_m1_cyc", s_cyc_o, 1'b1);
    checkOutput("t6_m1_adr", s_adr_o, 32'h2000);
    applyStimulus();
    idleInputs();
    applyStimulus();

    // Randomized traffic with quiet-slave stretches to exercise the watchdog.
    silent = 0;
    for (int k = 0; k < 3000; k++) begin
      if (k % 64 == 0) silent = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 299) != 0);
      if (m0_cyc_i) m0_cyc_i = ($urandom_range(0, 5) != 0);
      else          m0_cyc_i = ($urandom_range(0, 2) == 0);
      if (m1_cyc_i) m1_cyc_i = ($urandom_range(0, 5) != 0);
      else          m1_cyc_i = ($urandom_range(0, 2) == 0);
      m0_stb_i = m0_cyc_i && ($urandom_range(0, 3) != 0);
      m1_stb_i = m1_cyc_i && ($urandom_range(0, 3) != 0);
      m0_adr_i = $urandom; m1_adr_i = $urandom;
      m0_dat_i = $urandom; m1_dat_i = $urandom;
      m0_we_i  = $urandom_range(0, 1); m1_we_i = $urandom_range(0, 1);
      m0_sel_i = SW'($urandom); m1_sel_i = SW'($urandom);
      s_dat_i  = $urandom;
      s_ack_i  = !silent && ($urandom_range(0, 2) == 0);
      s_err_i  = !silent && ($urandom_range(0, 15) == 0);
      applyStimulus();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
